// File: rtl/ps2_pkg.sv
// Shared FSM encoding and scan-code byte constants for the PS/2 scan-code controller.
// Names the prefix bytes and the protocol bytes that never become key events.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2,
        EMIT = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_RESND = 8'hFE;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_ERR1  = 8'hFF;

    // Keyboard status/protocol bytes that carry no key identity.
    function automatic logic ps2_is_drop(input logic [7:0] b);
        logic d;
        d = 1'b0;
        case (b)
            PS2_PAUSE, PS2_BAT, PS2_ECHO, PS2_ACK,
            PS2_RESND, PS2_ERR0, PS2_ERR1: d = 1'b1;
            default:                        d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Watchdog for a pending E0/F0 prefix: fires once after TIMEOUT_CYC running cycles.
// A clear (pop or nothing pending) restarts it from zero.
module ps2_prefix_timer #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic clrn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] timer;

    assign expire = run && !clear && (timer == LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            timer <= '0;
        end else if (clear || expire) begin
            timer <= '0;
        end else if (run) begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Drains the PS/2 receiver FIFO one byte per pass, folds E0/F0 prefixes into key
// events, and presents them on a valid/ack port with held-key and press tracking.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             key_valid,
    input  logic             key_ack,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic             key_held,
    output logic [CNT_W-1:0] key_count,
    output logic             err
);

    ps2_state_e state, state_nxt;

    logic [7:0] byte_r;
    logic       ext_p;
    logic       brk_p;
    logic [7:0] held_code;
    logic       held_ext;

    logic       byte_is_ext;
    logic       byte_is_brk;
    logic       byte_is_drop;
    logic       byte_is_event;
    logic       match_held;

    logic       tmr_run;
    logic       tmr_clear;
    logic       tmr_expire;

    // Byte classification of the latched FIFO head, consumed in GAP.
    always_comb begin
        byte_is_ext   = (byte_r == PS2_EXT);
        byte_is_brk   = (byte_r == PS2_BRK);
        byte_is_drop  = ps2_is_drop(byte_r);
        byte_is_event = !(byte_is_ext || byte_is_brk || byte_is_drop);
        match_held    = key_held && (byte_r == held_code) && (ext_p == held_ext);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ps2_ready) state_nxt = POP;
            POP:  state_nxt = GAP;
            GAP:  state_nxt = byte_is_event ? EMIT : IDLE;
            EMIT: if (key_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state          <= IDLE;
            ps2_nextdata_n <= 1'b1;
        end else begin
            state          <= state_nxt;
            ps2_nextdata_n <= !(state_nxt == POP);
        end
    end

    assign tmr_run   = (state == IDLE) && (ext_p || brk_p);
    assign tmr_clear = (state == POP) || !(ext_p || brk_p);

    ps2_prefix_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_prefix_timer (
        .clk    (clk),
        .clrn   (clrn),
        .run    (tmr_run),
        .clear  (tmr_clear),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_r <= '0;
            ext_p  <= 1'b0;
            brk_p  <= 1'b0;
        end else begin
            if (state == POP) begin
                byte_r <= ps2_data;
            end
            if (tmr_expire) begin
                ext_p <= 1'b0;
                brk_p <= 1'b0;
            end else if (state == GAP) begin
                if (byte_is_ext) begin
                    ext_p <= 1'b1;
                end else if (byte_is_brk) begin
                    brk_p <= 1'b1;
                end else begin
                    ext_p <= 1'b0;
                    brk_p <= 1'b0;
                end
            end
        end
    end

    // Event outputs and held/count bookkeeping all update on the GAP cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_repeat <= 1'b0;
            key_held   <= 1'b0;
            key_count  <= '0;
            held_code  <= '0;
            held_ext   <= 1'b0;
        end else begin
            if (state == GAP && byte_is_event) begin
                key_valid <= 1'b1;
                key_code  <= byte_r;
                key_ext   <= ext_p;
                key_break <= brk_p;
                if (!brk_p) begin
                    if (match_held) begin
                        key_repeat <= 1'b1;
                    end else begin
                        key_repeat <= 1'b0;
                        key_count  <= key_count + CNT_W'(1);
                        held_code  <= byte_r;
                        held_ext   <= ext_p;
                        key_held   <= 1'b1;
                    end
                end else begin
                    key_repeat <= 1'b0;
                    if (match_held) begin
                        key_held <= 1'b0;
                    end
                end
            end else if (state == EMIT && key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err <= 1'b0;
        end else if (ps2_overflow || tmr_expire) begin
            err <= 1'b1;
        end
    end

endmodule
